// File: rtl/kf_pkg.sv
// Shared encodings for the Kalman-filter micro-sequencer: instruction fields,
// operation/multiplier/immediate selectors, error codes and FSM states.
package kf_pkg;

  localparam int INSTR_W   = 22;
  localparam int F_END     = 21;
  localparam int F_OP_HI   = 20;
  localparam int F_OP_LO   = 19;
  localparam int F_MULY_HI = 18;
  localparam int F_MULY_LO = 17;
  localparam int F_IMM_HI  = 16;
  localparam int F_IMM_LO  = 15;
  localparam int F_DST_HI  = 14;
  localparam int F_DST_LO  = 11;
  localparam int F_SRCA_HI = 10;
  localparam int F_SRCA_LO = 7;
  localparam int F_SRCB_HI = 6;
  localparam int F_SRCB_LO = 3;
  localparam int F_PAD_HI  = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  // Second multiplier operand: S, the immediate, R (square); 11 is reserved.
  typedef enum logic [1:0] {
    MULY_S   = 2'b00,
    MULY_IMM = 2'b01,
    MULY_R   = 2'b10,
    MULY_BAD = 2'b11
  } muly_e;

  // Immediate: 0, +1.0, -1.0 in Q(FRAC) sign-magnitude; 11 is reserved.
  typedef enum logic [1:0] {
    IMM_ZERO = 2'b00,
    IMM_POS1 = 2'b01,
    IMM_NEG1 = 2'b10,
    IMM_BAD  = 2'b11
  } imm_sel_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_PC      = 2'b10,
    ERR_TMO     = 2'b11
  } err_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_WB    = 3'd5
  } state_e;

endpackage

// File: rtl/kf_regfile.sv
// NREG x W register file: one write port, three combinational read ports,
// cleared synchronously while reset is asserted.
module kf_regfile #(
  parameter int W    = 24,
  parameter int NREG = 16,
  parameter int AW   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] ra_addr,
  output logic [W-1:0]  ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [W-1:0]  rb_data,
  input  logic [AW-1:0] rh_addr,
  output logic [W-1:0]  rh_data
);

  logic [W-1:0] rf [NREG];

  // Clear everything on reset, otherwise accept at most one write per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (we) begin
      rf[waddr] <= wdata;
    end
  end

  assign ra_data = rf[ra_addr];
  assign rb_data = rf[rb_addr];
  assign rh_data = rf[rh_addr];

endmodule

// File: rtl/kf_op_seq.sv
// Micro-instruction sequencer feeding the sign-magnitude arithmetic unit.
//
// state | meaning
// IDLE  | waiting for an accepted go; host owns the register file
// FETCH | program memory read of pc
// LOAD  | decode instruction, capture operands/controls onto au_* outputs
// ISSUE | one-cycle au_start, arm the completion timeout
// WAIT  | wait for au_done or timeout
// WB    | write au_result to dst, then finish, overrun or advance pc
module kf_op_seq #(
  parameter int W    = 24,
  parameter int FRAC = 14,
  parameter int NREG = 16,
  parameter int PAW  = 6,
  parameter int TMO  = 63
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           go,
  input  logic [PAW-1:0] start_pc,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [1:0]     err_code,
  output logic [PAW-1:0] prog_addr,
  output logic           prog_en,
  input  logic [21:0]    prog_data,
  input  logic           ld_we,
  input  logic [3:0]     ld_addr,
  input  logic [W-1:0]   ld_data,
  input  logic [3:0]     rd_addr,
  output logic [W-1:0]   rd_data,
  output logic           au_start,
  output logic [W-1:0]   au_R,
  output logic [W-1:0]   au_S,
  output logic [W-1:0]   au_Iimm,
  output logic [1:0]     au_op_sel,
  output logic [1:0]     au_mul_y_sel,
  input  logic [W-1:0]   au_result,
  input  logic           au_done,
  input  logic           au_busy
);
  import kf_pkg::*;

  localparam int TW = $clog2(TMO + 1);
  localparam logic [W-1:0] IMM_ONE     = W'(1) << FRAC;
  localparam logic [W-1:0] IMM_NEG_ONE = IMM_ONE | (W'(1) << (W - 1));

  state_e         state, state_d;
  logic [PAW-1:0] pc;
  logic           end_q;
  logic [3:0]     dst_q;
  logic [TW-1:0]  tmo_cnt;
  logic           au_busy_q;
  err_e           err_code_q, err_code_d;
  logic           accept, load_ok, wb_en, err_set, pc_inc, tmo_load, tmo_dec;

  logic           i_end;
  logic [1:0]     i_op, i_muly;
  imm_sel_e       i_imm;
  logic [3:0]     i_dst, i_srca, i_srcb;
  logic           illegal;
  logic [W-1:0]   imm_val, ra_data, rb_data;
  logic           rf_we;

  assign i_end  = prog_data[F_END];
  assign i_op   = prog_data[F_OP_HI:F_OP_LO];
  assign i_muly = prog_data[F_MULY_HI:F_MULY_LO];
  assign i_imm  = imm_sel_e'(prog_data[F_IMM_HI:F_IMM_LO]);
  assign i_dst  = prog_data[F_DST_HI:F_DST_LO];
  assign i_srca = prog_data[F_SRCA_HI:F_SRCA_LO];
  assign i_srcb = prog_data[F_SRCB_HI:F_SRCB_LO];

  assign illegal = (i_imm == IMM_BAD)
                 || (i_op == OP_MUL && i_muly == MULY_BAD)
                 || (prog_data[F_PAD_HI:0] != 3'b000);

  // Immediate operand value for the instruction being decoded.
  always_comb begin
    imm_val = '0;
    case (i_imm)
      IMM_POS1: imm_val = IMM_ONE;
      IMM_NEG1: imm_val = IMM_NEG_ONE;
      default:  imm_val = '0;
    endcase
  end

  // Writeback has the port in WB; the host only ever writes while idle.
  assign rf_we = wb_en || (state == S_IDLE && ld_we);

  kf_regfile #(.W(W), .NREG(NREG), .AW(4)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (wb_en ? dst_q : ld_addr),
    .wdata   (wb_en ? au_result : ld_data),
    .ra_addr (i_srca),
    .ra_data (ra_data),
    .rb_addr (i_srcb),
    .rb_data (rb_data),
    .rh_addr (rd_addr),
    .rh_data (rd_data)
  );

  assign busy      = (state != S_IDLE);
  assign prog_addr = pc;
  assign err_code  = err_code_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next state plus single-cycle strobes.
  always_comb begin
    state_d    = state;
    accept     = 1'b0;
    load_ok    = 1'b0;
    wb_en      = 1'b0;
    err_set    = 1'b0;
    err_code_d = ERR_NONE;
    pc_inc     = 1'b0;
    tmo_load   = 1'b0;
    tmo_dec    = 1'b0;
    done       = 1'b0;
    au_start   = 1'b0;
    prog_en    = 1'b0;
    case (state)
      S_IDLE: begin
        // Two quiet au_busy cycles: the reset-less AU may still be dividing.
        if (go && !au_busy && !au_busy_q) begin
          accept  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        prog_en = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (illegal) begin
          err_set    = 1'b1;
          err_code_d = ERR_ILLEGAL;
          state_d    = S_IDLE;
        end else begin
          load_ok = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        au_start = 1'b1;
        tmo_load = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (au_done) begin
          state_d = S_WB;
        end else if (tmo_cnt == '0) begin
          err_set    = 1'b1;
          err_code_d = ERR_TMO;
          state_d    = S_IDLE;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      S_WB: begin
        wb_en = 1'b1;
        if (end_q) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (pc == {PAW{1'b1}}) begin
          err_set    = 1'b1;
          err_code_d = ERR_PC;
          state_d    = S_IDLE;
        end else begin
          pc_inc  = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Program counter, sticky error, timeout down-counter and AU busy history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= '0;
      err        <= 1'b0;
      err_code_q <= ERR_NONE;
      tmo_cnt    <= '0;
      au_busy_q  <= 1'b0;
    end else begin
      au_busy_q <= au_busy;
      if (accept) begin
        pc         <= start_pc;
        err        <= 1'b0;
        err_code_q <= ERR_NONE;
      end else if (pc_inc) begin
        pc <= pc + 1'b1;
      end
      if (err_set) begin
        err        <= 1'b1;
        err_code_q <= err_code_d;
      end
      if (tmo_load)     tmo_cnt <= TW'(TMO - 1);
      else if (tmo_dec) tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  // Operands and controls captured in LOAD and held through WB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      end_q        <= 1'b0;
      dst_q        <= '0;
      au_R         <= '0;
      au_S         <= '0;
      au_Iimm      <= '0;
      au_op_sel    <= '0;
      au_mul_y_sel <= '0;
    end else if (load_ok) begin
      end_q        <= i_end;
      dst_q        <= i_dst;
      au_R         <= ra_data;
      au_S         <= rb_data;
      au_Iimm      <= imm_val;
      au_op_sel    <= i_op;
      au_mul_y_sel <= i_muly;
    end
  end

endmodule
